// File: rtl/pc_src_sequencer_pkg.sv
// Shared definitions for the PC source sequencer: sequencer state encoding,
// RV32 opcode constants, branch func3 codes and PC source mux select codes.
// Also holds the port field widths used by the bus interface.
package pc_src_sequencer_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned PC_SEL_W = 3;
   localparam int unsigned STATE_W  = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } seq_state_t;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

   localparam logic [FUNC3_W-1:0] F3_BEQ  = 3'b000;
   localparam logic [FUNC3_W-1:0] F3_BNE  = 3'b001;
   localparam logic [FUNC3_W-1:0] F3_BLT  = 3'b100;
   localparam logic [FUNC3_W-1:0] F3_BGE  = 3'b101;
   localparam logic [FUNC3_W-1:0] F3_BLTU = 3'b110;
   localparam logic [FUNC3_W-1:0] F3_BGEU = 3'b111;

   localparam logic [PC_SEL_W-1:0] PC_SEL_PC4    = 3'd0;
   localparam logic [PC_SEL_W-1:0] PC_SEL_JALR   = 3'd1;
   localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 3'd2;
   localparam logic [PC_SEL_W-1:0] PC_SEL_JAL    = 3'd3;
   localparam logic [PC_SEL_W-1:0] PC_SEL_MTVEC  = 3'd4;
   localparam logic [PC_SEL_W-1:0] PC_SEL_MEPC   = 3'd5;

endpackage

// File: rtl/pc_src_sequencer_if.sv
// Bus between the instruction decode/datapath side and the PC source
// sequencer.
//   master : drives instruction fields, branch compare results, interrupt
//            request and mstatus.MIE; receives PC control outputs.
//   slave  : the sequencer itself.
// Signals: opcode[6:0], func3[2:0], ir_mret, br_eq, br_lt, br_ltu, intr, mie
//          (toward sequencer); pc_sel[2:0], pc_we, mem_rden1, int_taken,
//          state[2:0] (from sequencer).
interface pc_src_sequencer_if;
   import pc_src_sequencer_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic [FUNC3_W-1:0]  func3;
   logic                ir_mret;
   logic                br_eq;
   logic                br_lt;
   logic                br_ltu;
   logic                intr;
   logic                mie;
   logic [PC_SEL_W-1:0] pc_sel;
   logic                pc_we;
   logic                mem_rden1;
   logic                int_taken;
   logic [STATE_W-1:0]  state;

   modport master (
      output opcode, func3, ir_mret, br_eq, br_lt, br_ltu, intr, mie,
      input  pc_sel, pc_we, mem_rden1, int_taken, state
   );

   modport slave (
      input  opcode, func3, ir_mret, br_eq, br_lt, br_ltu, intr, mie,
      output pc_sel, pc_we, mem_rden1, int_taken, state
   );

endinterface

// File: rtl/pc_src_sequencer_branch_cond_gen.sv
// Branch condition generator: combinational decode of func3 against the
// rs1/rs2 compare flags.
// Ports: func3[2:0], br_eq, br_lt, br_ltu in; taken out.
// func3 010/011 are not branch encodings and never report taken.
module branch_cond_gen
   import pc_src_sequencer_pkg::*;
(
   input  logic [FUNC3_W-1:0] func3,
   input  logic               br_eq,
   input  logic               br_lt,
   input  logic               br_ltu,
   output logic               taken
);

   always_comb begin
      taken = 1'b0;
      case (func3)
         F3_BEQ:  taken = br_eq;
         F3_BNE:  taken = ~br_eq;
         F3_BLT:  taken = br_lt;
         F3_BGE:  taken = ~br_lt;
         F3_BLTU: taken = br_ltu;
         F3_BGEU: taken = ~br_ltu;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_src_sequencer.sv
// PC source sequencer: multicycle control for fetch / execute / writeback
// and trap entry, producing the PC source mux select and PC load enable.
// Ports: clk, rst_n (synchronous, active-low), bus (pc_src_sequencer_if.slave).
// Parameter FETCH_WAIT (1..7): FETCH cycles covering instruction memory latency.
// Build option: define PC_SEQ_INTR_EN to enable interrupt pending/trap entry;
// without it intr/mie are ignored, INTR is unreachable and int_taken stays 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | one idle cycle after reset
// ST_FETCH | instruction read, held FETCH_WAIT cycles
// ST_EXEC  | PC update for non-loads (select depends on opcode), loads wait
// ST_WB    | load writeback, PC <= PC+4
// ST_INTR  | trap entry, PC <= MTVEC, int_taken pulse
module pc_src_sequencer
   import pc_src_sequencer_pkg::*;
#(
   parameter int unsigned FETCH_WAIT = 1
)
(
   input logic               clk,
   input logic               rst_n,
   pc_src_sequencer_if.slave bus
);

   localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT - 1);

   seq_state_t          state_q;
   seq_state_t          state_d;
   seq_state_t          exit_state;
   logic [2:0]          wait_cnt_q;
   logic                fetch_done;
   logic                intr_pend_q;
   logic                br_taken;
   logic                is_load;
   logic [PC_SEL_W-1:0] exec_sel;
   logic [PC_SEL_W-1:0] pc_sel;
   logic                pc_we;
   logic                mem_rden1;
   logic                int_taken;

   branch_cond_gen u_branch_cond_gen (
      .func3  (bus.func3),
      .br_eq  (bus.br_eq),
      .br_lt  (bus.br_lt),
      .br_ltu (bus.br_ltu),
      .taken  (br_taken)
   );

   assign is_load    = (bus.opcode == OP_LOAD);
   assign fetch_done = (wait_cnt_q == WAIT_LAST);
   assign exit_state = intr_pend_q ? ST_INTR : ST_FETCH;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter rests at zero outside FETCH, so every FETCH entry starts clean.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else if ((state_q == ST_FETCH) && !fetch_done) begin
         wait_cnt_q <= wait_cnt_q + 3'd1;
      end else begin
         wait_cnt_q <= '0;
      end
   end

`ifdef PC_SEQ_INTR_EN
   // A new request in the INTR cycle re-arms the pending flag (set wins).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         intr_pend_q <= 1'b0;
      end else begin
         intr_pend_q <= (intr_pend_q && (state_q != ST_INTR)) || (bus.intr && bus.mie);
      end
   end
`else
   logic unused_irq;
   assign unused_irq  = bus.intr ^ bus.mie;
   assign intr_pend_q = 1'b0;
`endif

   always_comb begin
      state_d = ST_INIT;
      case (state_q)
         ST_INIT:  state_d = ST_FETCH;
         ST_FETCH: state_d = fetch_done ? ST_EXEC : ST_FETCH;
         ST_EXEC:  state_d = is_load ? ST_WB : exit_state;
         ST_WB:    state_d = exit_state;
`ifdef PC_SEQ_INTR_EN
         ST_INTR:  state_d = ST_FETCH;
`endif
         default:  state_d = ST_INIT;
      endcase
   end

   // MRET still loads MEPC even with an interrupt pending; trap entry
   // follows in the next cycle.
   always_comb begin
      exec_sel = PC_SEL_PC4;
      case (bus.opcode)
         OP_JAL:    exec_sel = PC_SEL_JAL;
         OP_JALR:   exec_sel = PC_SEL_JALR;
         OP_BRANCH: exec_sel = br_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
         OP_SYSTEM: exec_sel = bus.ir_mret ? PC_SEL_MEPC : PC_SEL_PC4;
         default:   exec_sel = PC_SEL_PC4;
      endcase
   end

   // Outputs are forced idle while rst_n is low, whatever the current state.
   always_comb begin
      pc_sel    = PC_SEL_PC4;
      pc_we     = 1'b0;
      mem_rden1 = 1'b0;
      int_taken = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: mem_rden1 = 1'b1;
            ST_EXEC: begin
               if (!is_load) begin
                  pc_we  = 1'b1;
                  pc_sel = exec_sel;
               end
            end
            ST_WB:    pc_we = 1'b1;
`ifdef PC_SEQ_INTR_EN
            ST_INTR: begin
               pc_we     = 1'b1;
               pc_sel    = PC_SEL_MTVEC;
               int_taken = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.pc_sel    = pc_sel;
   assign bus.pc_we     = pc_we;
   assign bus.mem_rden1 = mem_rden1;
   assign bus.int_taken = int_taken;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pc_src_sequencer.sv
// Testbench for pc_src_sequencer. Two instances share one stimulus: a
// default FETCH_WAIT=1 instance checked during start-up only, and a
// FETCH_WAIT=3 instance checked against an instruction-level reference model
// for directed and randomized instruction streams. Honours PC_SEQ_INTR_EN.
module tb_pc_src_sequencer;
   import pc_src_sequencer_pkg::*;

   localparam int FW = 3;
   localparam logic [6:0] R_LOAD   = 7'b0000011;
   localparam logic [6:0] R_JAL    = 7'b1101111;
   localparam logic [6:0] R_JALR   = 7'b1100111;
   localparam logic [6:0] R_BRANCH = 7'b1100011;
   localparam logic [6:0] R_SYSTEM = 7'b1110011;
   localparam logic [6:0] R_ADDI   = 7'b0010011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       ir_mret, br_eq, br_lt, br_ltu, intr, mie;

   int n_chk  = 0;
   int n_fail = 0;
   bit pend   = 1'b0;
   bit rnd_irq = 1'b0;

   always #5 clk = ~clk;

   pc_src_sequencer_if bus1();
   pc_src_sequencer_if bus3();

   assign bus1.opcode  = opcode;
   assign bus1.func3   = func3;
   assign bus1.ir_mret = ir_mret;
   assign bus1.br_eq   = br_eq;
   assign bus1.br_lt   = br_lt;
   assign bus1.br_ltu  = br_ltu;
   assign bus1.intr    = intr;
   assign bus1.mie     = mie;
   assign bus3.opcode  = opcode;
   assign bus3.func3   = func3;
   assign bus3.ir_mret = ir_mret;
   assign bus3.br_eq   = br_eq;
   assign bus3.br_lt   = br_lt;
   assign bus3.br_ltu  = br_ltu;
   assign bus3.intr    = intr;
   assign bus3.mie     = mie;

   pc_src_sequencer #(.FETCH_WAIT(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   pc_src_sequencer #(.FETCH_WAIT(FW)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference PC select from the instruction-level rules.
   function automatic logic [2:0] ref_sel(input logic [6:0] op, input logic [2:0] f3,
                                          input logic mret, input logic eq,
                                          input logic lt, input logic ltu);
      logic cond;
      logic taken;
      cond  = f3[2] ? (f3[1] ? ltu : lt) : eq;
      taken = (f3[2:1] != 2'b01) && (cond ^ f3[0]);
      if (op == R_JAL)  return 3'd3;
      if (op == R_JALR) return 3'd1;
      if (op == R_BRANCH) return taken ? 3'd2 : 3'd0;
      if ((op == R_SYSTEM) && mret) return 3'd5;
      return 3'd0;
   endfunction

   // One clock cycle of the FW=3 instance: check outputs mid-cycle, then
   // advance the pending-interrupt model across the edge.
   task automatic step(input string tag, input logic [2:0] e_st, input logic [2:0] e_sel,
                       input logic e_we, input logic e_rden, input logic e_it);
      if (rnd_irq) begin
         intr = ($urandom_range(0, 5) == 0);
         mie  = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      chk({tag, "_state"}, bus3.state, e_st);
      chk({tag, "_sel"},   bus3.pc_sel, e_sel);
      chk({tag, "_we"},    3'(bus3.pc_we), 3'(e_we));
      chk({tag, "_rden"},  3'(bus3.mem_rden1), 3'(e_rden));
      chk({tag, "_itkn"},  3'(bus3.int_taken), 3'(e_it));
      @(posedge clk);
`ifdef PC_SEQ_INTR_EN
      pend = (pend && !e_it) || (intr && mie);
`endif
      #1;
   endtask

   task automatic do_reset(input string tag, input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_sel"},  bus3.pc_sel, 3'd0);
         chk({tag, "_we"},   3'(bus3.pc_we), 3'd0);
         chk({tag, "_rden"}, 3'(bus3.mem_rden1), 3'd0);
         chk({tag, "_itkn"}, 3'(bus3.int_taken), 3'd0);
         if (i > 0) chk({tag, "_state"}, bus3.state, ST_INIT);
         @(posedge clk);
         #1;
      end
      pend  = 1'b0;
      rst_n = 1'b1;
      step({tag, "_init"}, ST_INIT, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // One instruction from first FETCH cycle to the cycle before the next
   // FETCH. irq_at selects a FETCH cycle that raises intr (directed mode).
   task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic mret, input logic eq, input logic lt,
                            input logic ltu, input int irq_at, input logic irq_mie);
      logic [2:0] sel;
      bit         exit_pend;
      opcode  = op;
      func3   = f3;
      ir_mret = mret;
      br_eq   = eq;
      br_lt   = lt;
      br_ltu  = ltu;
      sel = ref_sel(op, f3, mret, eq, lt, ltu);
      for (int i = 0; i < FW; i++) begin
         if (!rnd_irq) begin
            intr = (i == irq_at);
            mie  = irq_mie;
         end
         step({tag, "_fetch"}, ST_FETCH, 3'd0, 1'b0, 1'b1, 1'b0);
      end
      if (!rnd_irq) intr = 1'b0;
      if (op == R_LOAD) begin
         step({tag, "_exec"}, ST_EXEC, 3'd0, 1'b0, 1'b0, 1'b0);
         exit_pend = pend;
         step({tag, "_wb"}, ST_WB, 3'd0, 1'b1, 1'b0, 1'b0);
      end else begin
         exit_pend = pend;
         step({tag, "_exec"}, ST_EXEC, sel, 1'b1, 1'b0, 1'b0);
      end
      if (exit_pend) step({tag, "_intr"}, ST_INTR, 3'd4, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      logic [2:0] e1;
      logic [2:0] e3;
      logic [6:0] op;
      rst_n   = 1'b0;
      opcode  = R_ADDI;
      func3   = 3'd0;
      ir_mret = 1'b0;
      br_eq   = 1'b0;
      br_lt   = 1'b0;
      br_ltu  = 1'b0;
      intr    = 1'b0;
      mie     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Start-up with a plain ALU instruction held, both fetch latencies.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         e1 = (c == 0) ? ST_INIT : (((c % 2) == 1) ? ST_FETCH : ST_EXEC);
         e3 = (c == 0) ? ST_INIT : ((c <= 3) ? ST_FETCH : ST_EXEC);
         chk("fw1_state", bus1.state, e1);
         chk("fw1_rden",  3'(bus1.mem_rden1), 3'(e1 == ST_FETCH));
         chk("fw1_we",    3'(bus1.pc_we), 3'(e1 == ST_EXEC));
         chk("fw1_sel",   bus1.pc_sel, 3'd0);
         chk("fw3_state", bus3.state, e3);
         chk("fw3_rden",  3'(bus3.mem_rden1), 3'(e3 == ST_FETCH));
         chk("fw3_we",    3'(bus3.pc_we), 3'(e3 == ST_EXEC));
         @(posedge clk);
         #1;
      end

      do_reset("rst0", 2);
      run_instr("addi",      R_ADDI,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      run_instr("bne_tkn",   R_BRANCH, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      run_instr("bne_ntkn",  R_BRANCH, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      run_instr("br_f3_010", R_BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0);
      run_instr("bgeu_tkn",  R_BRANCH, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      run_instr("load",      R_LOAD,   3'b010, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      run_instr("jalr",      R_JALR,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      run_instr("jal_irq",   R_JAL,    3'b000, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b1);
      run_instr("jal_nomie", R_JAL,    3'b000, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0);
      run_instr("mret_irq",  R_SYSTEM, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0,  0, 1'b1);
      run_instr("load_irq",  R_LOAD,   3'b010, 1'b0, 1'b0, 1'b0, 1'b0,  2, 1'b1);

      // Interrupt raised during a JAL, then reset while in trap entry
      // (or mid-FETCH when interrupts are compiled out).
      opcode = R_JAL;
      for (int i = 0; i < FW; i++) begin
         intr = (i == 0);
         mie  = 1'b1;
         step("rstint_fetch", ST_FETCH, 3'd0, 1'b0, 1'b1, 1'b0);
      end
      intr = 1'b0;
      step("rstint_exec", ST_EXEC, 3'd3, 1'b1, 1'b0, 1'b0);
      do_reset("rst_intr", 2);

      rnd_irq = 1'b1;
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 6))
            0:       op = R_LOAD;
            1:       op = R_JAL;
            2:       op = R_JALR;
            3:       op = R_BRANCH;
            4:       op = R_SYSTEM;
            5:       op = R_ADDI;
            default: op = 7'($urandom);
         endcase
         if ($urandom_range(0, 24) == 0) do_reset("rnd_rst", int'($urandom_range(1, 3)));
         run_instr("rnd", op, 3'($urandom), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1), -1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
